// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle instruction sequencer FSM.
// Walks each instruction through FETCH -> DECODE -> EXEC -> MEM -> WB and
// emits single-cycle datapath strobes plus memory handshake requests.
// The instruction word is numbered MSB-first externally (bit 0 = MSB), so
// the opcode field [0:5] lands on [31:26] of the descending port vector.
// Optional feature: define SEQ_PERF_CNT_EN to add the 32-bit 'retired'
// counter port (counts cycles with pc_inc or pc_load, wrapping).
`timescale 1ns/1ps

module instr_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] instruction,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        ir_load,
  output logic [1:0]  fmt_sel,
  output logic        alu_en,
  output logic        rf_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        busy,
  output logic        halted,
  output logic [2:0]  state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LOAD  = 6'h23;
  localparam logic [5:0] OP_STORE = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic [1:0] fmt_q, fmt_d;

  // Only the opcode field is consumed here; operand fields go to the datapath.
  logic unused_operand_bits;
  assign unused_operand_bits = ^instruction[25:0];

  // Decoder format for an opcode: R-type, jump (J), everything else I-type.
  function automatic logic [1:0] fmt_of(input logic [5:0] op);
    if (op == OP_RTYPE)                 return 2'b00;
    else if (op == OP_J || op == OP_JAL) return 2'b10;
    else                                return 2'b01;
  endfunction

  // State, latched opcode and decoder select registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= 6'd0;
      fmt_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      fmt_q    <= fmt_d;
    end
  end

  // Next-state logic and per-state strobes/requests.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    fmt_d    = fmt_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_load  = 1'b0;
    alu_en   = 1'b0;
    rf_we    = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    halted   = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load  = 1'b1;
          opcode_d = instruction[31:26];
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        busy    = 1'b1;
        fmt_d   = fmt_of(opcode_q);
        state_d = (opcode_q == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        busy   = 1'b1;
        alu_en = 1'b1;
        if (opcode_q == OP_J) begin
          pc_load = 1'b1;
          state_d = S_FETCH;
        end else if (opcode_q == OP_JAL) begin
          pc_load = 1'b1;
          state_d = S_WB;
        end else if (opcode_q == OP_LOAD || opcode_q == OP_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        busy     = 1'b1;
        dmem_req = 1'b1;
        if (dmem_ack) begin
          // A store retires here; a load still needs its register write.
          if (opcode_q == OP_STORE) begin
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        busy    = 1'b1;
        rf_we   = 1'b1;
        // jal already redirected the PC in EXEC; only the link is written.
        pc_inc  = (opcode_q != OP_JAL);
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state   = state_q;
  assign fmt_sel = fmt_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;

  // Retired count advances on every PC update; natural wrap at 2^32.
  always_comb begin
    retired_d = retired_q;
    if (pc_inc || pc_load) retired_d = retired_q + 32'd1;
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk) begin
    if (reset) retired_q <= 32'd0;
    else       retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-instruction expected cycle
// traces derived from the opcode rules, with randomized opcodes, operand
// junk, handshake delays, spurious acks and stray run pulses.
`timescale 1ns/1ps

module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, imem_ack, dmem_ack;
  logic [31:0] instruction;
  logic        imem_req, dmem_req, ir_load, alu_en, rf_we, pc_inc, pc_load;
  logic        busy, halted;
  logic [1:0]  fmt_sel;
  logic [2:0]  state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired;
`endif

  instr_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instruction (instruction),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .dmem_req    (dmem_req),
    .dmem_ack    (dmem_ack),
    .ir_load     (ir_load),
    .fmt_sel     (fmt_sel),
    .alu_en      (alu_en),
    .rf_we       (rf_we),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .busy        (busy),
    .halted      (halted),
    .state       (state)
`ifdef SEQ_PERF_CNT_EN
    ,
    .retired     (retired)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [1:0]  model_fmt = 2'b00;
  logic [31:0] model_ret = 32'd0;
  string       cur_tag = "reset";

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cyc(input logic [2:0] st, input logic ireq, irl, dreq, alu, we, inc, ld,
                     input logic ia, da, rn, rs);
    logic [13:0] exp_v, obs_v;
    imem_ack = ia;
    dmem_ack = da;
    run      = rn;
    reset    = rs;
    @(negedge clk);
    exp_v = {st, (st >= 3'd1 && st <= 3'd5), (st == 3'd6), ireq, irl, dreq, alu, we, inc, ld,
             model_fmt};
    obs_v = {state, busy, halted, imem_req, ir_load, dmem_req, alu_en, rf_we, pc_inc, pc_load,
             fmt_sel};
    chk_eq(cur_tag, 32'(obs_v), 32'(exp_v));
`ifdef SEQ_PERF_CNT_EN
    chk_eq({cur_tag, "/retired"}, retired, model_ret);
`endif
    @(posedge clk);
    #1;
    if (rs) begin
      model_ret = 32'd0;
      model_fmt = 2'b00;
    end else if (inc || ld) begin
      model_ret = model_ret + 32'd1;
    end
    instruction = $urandom;
  endtask

  // Expected trace of one instruction starting in FETCH.
  task automatic exec_instr(input logic [5:0] op, input int fd, input int md);
    logic is_mem;
    is_mem = (op == 6'h23 || op == 6'h2B);
    $sformat(cur_tag, "op%02h", op);
    for (int i = 0; i < fd; i++)
      cyc(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, rbit(), rbit(), 0);
    instruction = {op, 26'($urandom)};
    cyc(3'd1, 1, 1, 0, 0, 0, 0, 0, 1, rbit(), rbit(), 0);
    cyc(3'd2, 0, 0, 0, 0, 0, 0, 0, rbit(), rbit(), rbit(), 0);
    model_fmt = (op == 6'h00) ? 2'b00 : (op == 6'h02 || op == 6'h03) ? 2'b10 : 2'b01;
    if (op == 6'h3F) return;
    cyc(3'd3, 0, 0, 0, 1, 0, 0, (op == 6'h02 || op == 6'h03), rbit(), rbit(), rbit(), 0);
    if (op == 6'h02) return;
    if (is_mem) begin
      for (int i = 0; i < md; i++)
        cyc(3'd4, 0, 0, 1, 0, 0, 0, 0, rbit(), 0, rbit(), 0);
      cyc(3'd4, 0, 0, 1, 0, 0, (op == 6'h2B), 0, rbit(), 1, rbit(), 0);
      if (op == 6'h2B) return;
    end
    cyc(3'd5, 0, 0, 0, 0, 1, (op != 6'h03), 0, rbit(), rbit(), rbit(), 0);
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 6'h00;
      1:       return 6'h02;
      2:       return 6'h03;
      3:       return 6'h23;
      4:       return 6'h2B;
      default: return 6'($urandom_range(0, 62));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; instruction = '0;
    @(posedge clk);
    #1;
    // Reset state, then IDLE ignoring stray acks until run.
    cur_tag = "reset";
    cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    cur_tag = "idle";
    for (int i = 0; i < 3; i++) cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, rbit(), rbit(), 0, 0);
    cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, rbit(), rbit(), 1, 0);

    // Directed: R-type, delayed load, jal, store, j, I-type, delayed fetch.
    exec_instr(6'h00, 0, 0);
    exec_instr(6'h23, 0, 3);
    exec_instr(6'h03, 0, 0);
    exec_instr(6'h2B, 0, 0);
    exec_instr(6'h02, 0, 0);
    exec_instr(6'h08, 2, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++)
      exec_instr(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3));

    // Halt: sticky, ignores run and acks.
    exec_instr(6'h3F, 1, 0);
    cur_tag = "halt";
    for (int i = 0; i < 5; i++) cyc(3'd6, 0, 0, 0, 0, 0, 0, 0, rbit(), rbit(), 1, 0);
    cyc(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cur_tag = "post_halt";
    cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Reset in MEM mid-handshake; late dmem_ack must be ignored.
    cur_tag = "abort_mem";
    instruction = {6'h23, 26'($urandom)};
    cyc(3'd1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_fmt = 2'b01;
    cyc(3'd3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(3'd4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(3'd4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

`ifdef SEQ_PERF_CNT_EN
    // Counter wrap on a single store.
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    model_ret = 32'hFFFF_FFFF;
`endif
    exec_instr(6'h2B, 0, 1);
    exec_instr(6'h00, 1, 0);
`ifdef SEQ_PERF_CNT_EN
    @(negedge clk);
    chk_eq("retired_wrap", retired, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
